aes_inv_mix_columns_seq: RTL

//  Iterative InvMixColumns engine for the decryption round datapath. Accepts a
//  128-bit AES state over a valid/ready handshake and applies InvMixColumns

---
 rtl/aes_pkg.sv | 56 +++++
 rtl/aes_inv_mix_single_column.sv | 31 +++
 rtl/aes_inv_mix_columns_seq.sv | 139 +++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) doubling, column access on the row-major state
// layout (byte (r,c) at bits 8*(4r+c)), and the enums used by the round datapath.
package aes_pkg;

  typedef enum logic {
    CIPH_FWD = 1'b0,
    CIPH_INV = 1'b1
  } ciph_op_e;

  typedef enum logic [1:0] {
    IMC_IDLE = 2'd0,
    IMC_BUSY = 2'd1,
    IMC_DONE = 2'd2
  } aes_imc_state_e;

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] aes_mul2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] aes_mul4(input logic [7:0] b);
    return aes_mul2(aes_mul2(b));
  endfunction

  // Column word packs row r at bits [8r +: 8].
  function automatic logic [31:0] aes_col_get(input logic [127:0] s, input logic [1:0] c);
    logic [31:0] col;
    col = 32'd0;
    for (int r = 0; r < 4; r++) begin
      col[8*r +: 8] = s[8*(4*r + int'(c)) +: 8];
    end
    return col;
  endfunction

  function automatic logic [127:0] aes_col_set(input logic [127:0] s, input logic [1:0] c,
                                               input logic [31:0] col);
    logic [127:0] t;
    t = s;
    for (int r = 0; r < 4; r++) begin
      t[8*(4*r + int'(c)) +: 8] = col[8*r +: 8];
    end
    return t;
  endfunction

  function automatic logic [127:0] aes_transpose(input logic [127:0] s);
    logic [127:0] t;
    t = 128'd0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        t[8*(4*c + r) +: 8] = s[8*(4*r + c) +: 8];
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/aes_inv_mix_single_column.sv
// Combinational InvMixColumns of one 32-bit column (row r at bits [8r +: 8]).
module aes_inv_mix_single_column
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  logic [7:0] a  [4];
  logic [7:0] x2 [4];
  logic [7:0] x4 [4];
  logic [7:0] x8 [4];
  logic [7:0] m9 [4];
  logic [7:0] mb [4];
  logic [7:0] md [4];
  logic [7:0] me [4];

  // Each output row is the circulant {0e,0b,0d,09} applied starting at that row.
  for (genvar r = 0; r < 4; r++) begin : g_row
    assign a[r]  = col_i[8*r +: 8];
    assign x2[r] = aes_mul2(a[r]);
    assign x4[r] = aes_mul4(a[r]);
    assign x8[r] = aes_mul2(x4[r]);
    assign m9[r] = x8[r] ^ a[r];
    assign mb[r] = x8[r] ^ x2[r] ^ a[r];
    assign md[r] = x8[r] ^ x4[r] ^ a[r];
    assign me[r] = x8[r] ^ x4[r] ^ x2[r];
    assign col_o[8*r +: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
  end

endmodule

// File: rtl/aes_inv_mix_columns_seq.sv
// Iterative InvMixColumns engine: accepts a state, transforms COLS_PER_CYCLE
// columns per clock, and holds the result until the consumer takes it.
module aes_inv_mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] data_o,
  output logic         busy_o
);

  localparam int          N        = COLS_PER_CYCLE;
  localparam logic [1:0]  COL_STEP = 2'(N);
  localparam logic [1:0]  LAST_COL = 2'(4 - N);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("aes_inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  aes_imc_state_e state_q, state_d;
  logic [1:0]     col_q, col_d;
  logic [127:0]   in_q, in_d;
  logic [127:0]   res_q, res_d;

  logic [1:0]     col_idx [N];
  logic [31:0]    col_in  [N];
  logic [31:0]    col_out [N];

  for (genvar k = 0; k < N; k++) begin : g_col
    assign col_idx[k] = col_q + 2'(k);
    assign col_in[k]  = aes_col_get(in_q, col_idx[k]);

    aes_inv_mix_single_column u_col (
      .col_i (col_in[k]),
      .col_o (col_out[k])
    );
  end

  // Next-state, column counter and datapath register updates.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    in_d    = in_q;
    res_d   = res_q;
    if (clear_i) begin
      state_d = IMC_IDLE;
      col_d   = 2'd0;
      in_d    = 128'd0;
      res_d   = 128'd0;
    end else begin
      case (state_q)
        IMC_IDLE: begin
          if (in_valid_i) begin
            in_d    = data_i;
            col_d   = 2'd0;
            state_d = IMC_BUSY;
          end else begin
            state_d = IMC_IDLE;
          end
        end
        IMC_BUSY: begin
          for (int k = 0; k < N; k++) begin
            res_d = aes_col_set(res_d, col_idx[k], col_out[k]);
          end
          col_d = col_q + COL_STEP;
          if (col_q == LAST_COL) begin
            state_d = IMC_DONE;
          end else begin
            state_d = IMC_BUSY;
          end
        end
        IMC_DONE: begin
          if (out_ready_i) begin
            // A waiting input is taken on the retire edge so there is no bubble.
            if (in_valid_i) begin
              in_d    = data_i;
              col_d   = 2'd0;
              state_d = IMC_BUSY;
            end else begin
              res_d   = 128'd0;
              state_d = IMC_IDLE;
            end
          end else begin
            state_d = IMC_DONE;
          end
        end
        default: begin
          state_d = IMC_IDLE;
          col_d   = 2'd0;
        end
      endcase
    end
  end

  // Handshake and data outputs decoded from the current state.
  always_comb begin
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b0;
    data_o      = 128'd0;
    case (state_q)
      IMC_IDLE: in_ready_o = 1'b1;
      IMC_BUSY: busy_o = 1'b1;
      IMC_DONE: begin
        out_valid_o = 1'b1;
        in_ready_o  = out_ready_i;
        data_o      = res_q;
      end
      default: begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IMC_IDLE;
      col_q   <= 2'd0;
      in_q    <= 128'd0;
      res_q   <= 128'd0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      in_q    <= in_d;
      res_q   <= res_d;
    end
  end

endmodule
